// File: rtl/prog_loader.sv
// prog_loader: receives a framed byte stream (SYNC, LEN, LEN x {hi,lo}, CHK),
// writes the assembled 16-bit words into instruction memory and holds the
// processor until a frame with a good checksum has been loaded.
module prog_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rxData,
    input  logic              rxValid,
    output logic              rxReady,
    output logic              memWr,
    output logic [ADDR_W-1:0] memAddr,
    output logic [15:0]       memData,
    output logic              cpuHold,
    output logic              busy,
    output logic              done,
    output logic              erro
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_WRITE,
        S_CHK
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t     state;
    state_t     state_next;
    logic [8:0] remaining;   // words still to write; 9 bits so LEN=0 can mean 256
    logic [7:0] sum;         // running modulo-256 sum of word bytes
    logic       accept;

    // Ready in every state except the write cycle; forced low while reset is held.
    assign rxReady = rst && (state != S_WRITE);
    assign accept  = rxValid && rxReady;
    assign memWr   = (state == S_WRITE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block ordering.
            state <= state_next;
        end
    end

    // Next-state logic: advance on each accepted byte, WRITE always lasts one cycle.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            S_IDLE:  if (accept && rxData == SYNC_BYTE) state_next = S_LEN;
            S_LEN:   if (accept) state_next = S_HI;
            S_HI:    if (accept) state_next = S_LO;
            S_LO:    if (accept) state_next = S_WRITE;
            S_WRITE: state_next = (remaining == 9'd1) ? S_CHK : S_HI;
            S_CHK:   if (accept) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: count, address, word assembly, checksum and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remaining <= 9'd0;
            sum       <= 8'd0;
            memAddr   <= '0;
            memData   <= 16'd0;
            cpuHold   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            erro      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    // Non-sync bytes in IDLE are consumed and dropped.
                    if (accept && rxData == SYNC_BYTE) begin
                        busy    <= 1'b1;
                        cpuHold <= 1'b1;
                        done    <= 1'b0;
                        erro    <= 1'b0;
                        sum     <= 8'd0;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        remaining <= (rxData == 8'd0) ? 9'd256 : {1'b0, rxData};
                        memAddr   <= '0;
                    end
                end
                S_HI: begin
                    if (accept) begin
                        memData[15:8] <= rxData;
                        sum           <= sum + rxData;
                    end
                end
                S_LO: begin
                    if (accept) begin
                        memData[7:0] <= rxData;
                        sum          <= sum + rxData;
                    end
                end
                S_WRITE: begin
                    remaining <= remaining - 9'd1;
                    // Address stays on the last written word at the end of a frame.
                    if (remaining != 9'd1) memAddr <= memAddr + ADDR_ONE;
                end
                S_CHK: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (rxData == sum) begin
                            done    <= 1'b1;
                            cpuHold <= 1'b0;
                        end else begin
                            erro <= 1'b1;   // processor stays held
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a driver sends randomized framed byte
// streams with stalls, pushing expected writes and frame outcomes into queues;
// a monitor pops and compares whenever the DUT writes or ends a frame.
module tb_prog_loader;

    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rxData = 8'd0;
    logic        rxValid = 1'b0;
    logic        rxReady;
    logic        memWr;
    logic [7:0]  memAddr;
    logic [15:0] memData;
    logic        cpuHold;
    logic        busy;
    logic        done;
    logic        erro;

    prog_loader #(.SYNC_BYTE(SYNC), .ADDR_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .rxData  (rxData),
        .rxValid (rxValid),
        .rxReady (rxReady),
        .memWr   (memWr),
        .memAddr (memAddr),
        .memData (memData),
        .cpuHold (cpuHold),
        .busy    (busy),
        .done    (done),
        .erro    (erro)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_wr[$];       // expected memory writes, in order
    bit          exp_res[$];      // expected frame outcome: 1 = good checksum
    logic [15:0] frame_words[$];  // words of the frame being built
    int          checks = 0;
    int          failures = 0;
    int          stall_pct = 30;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    logic prev_busy = 1'b0;
    logic prev_wr = 1'b0;
    wr_t  mon_e;
    bit   mon_good;
    always @(negedge clk) begin
        if (!rst) begin
            prev_busy = 1'b0;
            prev_wr   = 1'b0;
        end else begin
            check("ready_only_low_in_write", rxReady, !memWr);
            if (memWr) begin
                check("write_single_cycle", prev_wr, 1'b0);
                check("write_expected", exp_wr.size() > 0, 1'b1);
                if (exp_wr.size() > 0) begin
                    mon_e = exp_wr.pop_front();
                    check("mem_addr", memAddr, mon_e.addr);
                    check("mem_data", memData, mon_e.data);
                end
            end
            if (!prev_busy && busy) begin
                check("hold_at_frame_start", cpuHold, 1'b1);
                check("done_cleared_at_start", done, 1'b0);
                check("erro_cleared_at_start", erro, 1'b0);
            end
            if (prev_busy && !busy) begin
                check("frame_end_expected", exp_res.size() > 0, 1'b1);
                if (exp_res.size() > 0) begin
                    mon_good = exp_res.pop_front();
                    check("done_flag", done, mon_good);
                    check("erro_flag", erro, !mon_good);
                    check("cpu_hold_after_chk", cpuHold, !mon_good);
                end
            end
            prev_busy = busy;
            prev_wr   = memWr;
        end
    end

    // Present one byte (with an optional random gap first) and hold it until accepted.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        bit acc;
        if ($urandom_range(99) < stall_pct) begin
            rxValid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        rxData  = b;
        rxValid = 1'b1;
        waited  = 0;
        forever begin
            acc = rxReady;          // stable between edges; decides the coming edge
            @(negedge clk);
            if (acc) break;
            waited++;
            if (waited > 8) begin
                check("accept_timeout", waited, 0);
                break;
            end
        end
        rxValid = 1'b0;
    endtask

    // Reference model: expected writes are word i at address i; checksum is the
    // byte sum mod 256. A bad frame sends the correct sum plus one.
    task automatic run_frame(input bit good);
        int         n;
        logic [7:0] sum;
        n   = frame_words.size();
        sum = 8'd0;
        for (int i = 0; i < n; i++) begin
            sum = sum + frame_words[i][15:8] + frame_words[i][7:0];
            exp_wr.push_back('{addr: i[7:0], data: frame_words[i]});
        end
        exp_res.push_back(good);
        send_byte(SYNC);
        send_byte((n == 256) ? 8'h00 : 8'(n));
        for (int i = 0; i < n; i++) begin
            send_byte(frame_words[i][15:8]);
            send_byte(frame_words[i][7:0]);
        end
        send_byte(good ? sum : sum + 8'd1);
    endtask

    task automatic send_garbage(input int count);
        logic [7:0] g;
        for (int i = 0; i < count; i++) begin
            g = 8'($urandom_range(0, 255));
            if (g == SYNC) g = 8'h00;
            send_byte(g);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rxReady"}, rxReady, 1'b0);
        check({tag, "_memWr"},   memWr,   1'b0);
        check({tag, "_memAddr"}, memAddr, 8'd0);
        check({tag, "_memData"}, memData, 16'd0);
        check({tag, "_cpuHold"}, cpuHold, 1'b0);
        check({tag, "_busy"},    busy,    1'b0);
        check({tag, "_done"},    done,    1'b0);
        check({tag, "_erro"},    erro,    1'b0);
    endtask

    initial begin
        int n;
        int guard;
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", rxReady, 1'b1);

        // Two-word frame with good checksum.
        frame_words = '{16'h1234, 16'hABCD};
        run_frame(1'b1);

        // Same frame with a bad checksum, then a good one-word frame releases hold.
        run_frame(1'b0);
        repeat (3) @(negedge clk);
        check("hold_stays_after_error", cpuHold, 1'b1);
        check("erro_sticky", erro, 1'b1);
        frame_words = '{16'h0001};
        run_frame(1'b1);

        // Garbage before sync is discarded; SYNC value inside data is plain data.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'hA4);
        check("busy_after_garbage", busy, 1'b0);
        frame_words = '{16'hA5A5};
        run_frame(1'b1);

        // LEN=0: 256 words {i, ~i}, addresses 0..255.
        stall_pct = 10;
        frame_words.delete();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = i[7:0];
            frame_words.push_back({b, ~b});
        end
        run_frame(1'b1);
        repeat (2) @(negedge clk);
        check("addr_stops_at_255", memAddr, 8'd255);

        // Random frames with random stalls, garbage and checksum errors.
        stall_pct = 50;
        for (int f = 0; f < 12; f++) begin
            send_garbage($urandom_range(0, 2));
            frame_words.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) frame_words.push_back(16'($urandom));
            run_frame($urandom_range(0, 3) != 0);
        end

        // Reset after the third data byte of a four-word frame.
        stall_pct = 20;
        exp_wr.push_back('{addr: 8'd0, data: 16'h1122});
        send_byte(SYNC);
        send_byte(8'd4);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        check("first_word_written_before_reset", exp_wr.size(), 0);
        exp_wr.delete();
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        frame_words = '{16'hDEAD, 16'hBEEF, 16'hA5A5, 16'h0F0F};
        run_frame(1'b1);

        // Drain: all expected writes and frame outcomes must have been observed.
        guard = 0;
        while ((exp_wr.size() != 0 || exp_res.size() != 0) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("pending_writes", exp_wr.size(), 0);
        check("pending_frames", exp_res.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
